// File: rtl/reset_release_checker.sv
// reset_release_checker: holds producer reset (dut_rst_n) low HOLD_CYCLES on start, waits SETTLE_CYCLES, checks dut_result==EXPECTED for CHECK_CYCLES; reports busy/done/pass/reset_ok/mismatch_count/first_bad
module reset_release_checker #(
  parameter int WIDTH = 24,
  parameter logic [WIDTH-1:0] EXPECTED = 24'hC0FFEE,
  parameter int HOLD_CYCLES = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int CHECK_CYCLES = 8
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic [WIDTH-1:0]                      dut_result,
  output logic                                  dut_rst_n,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  pass,
  output logic                                  reset_ok,
  output logic [$clog2(CHECK_CYCLES+1)-1:0]     mismatch_count,
  output logic [WIDTH-1:0]                      first_bad
);
  localparam int MW = $clog2(CHECK_CYCLES + 1);
  localparam int M1 = HOLD_CYCLES > SETTLE_CYCLES ? HOLD_CYCLES : SETTLE_CYCLES;
  localparam int MAXC = M1 > CHECK_CYCLES ? M1 : CHECK_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  typedef enum logic [2:0] {IDLE, ASSERT, SETTLE, CHECK, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [MW-1:0] mm_q, mm_d;
  logic [WIDTH-1:0] first_bad_q, first_bad_d;
  logic pass_q, pass_d, reset_ok_q, reset_ok_d;
  logic dut_rst_n_q, dut_rst_n_d, busy_q, busy_d, done_q, done_d;
  logic last, bad;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q - CW'(1);
    mm_d = mm_q;
    first_bad_d = first_bad_q;
    pass_d = pass_q;
    reset_ok_d = reset_ok_q;
    last = cnt_q == '0;
    bad = dut_result !== EXPECTED;
    unique case (state_q)
      IDLE: begin
        cnt_d = CW'(HOLD_CYCLES - 1);
        if (start) begin
          state_d = ASSERT;
          pass_d = 1'b0;
          reset_ok_d = 1'b0;
          mm_d = '0;
          first_bad_d = '0;
        end
      end
      ASSERT: if (last) begin
        state_d = SETTLE;
        cnt_d = CW'(SETTLE_CYCLES - 1);
        reset_ok_d = dut_result === '0;
      end
      SETTLE: if (last) begin
        state_d = CHECK;
        cnt_d = CW'(CHECK_CYCLES - 1);
      end
      CHECK: begin
        if (bad) begin
          mm_d = mm_q == MW'(CHECK_CYCLES) ? mm_q : mm_q + MW'(1);
          first_bad_d = mm_q == '0 ? dut_result : first_bad_q;
        end
        if (last) begin
          state_d = DONE;
          pass_d = reset_ok_q && mm_d == '0;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    dut_rst_n_d = state_d != ASSERT;
    busy_d = state_d inside {ASSERT, SETTLE, CHECK};
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      mm_q <= '0;
      first_bad_q <= '0;
      pass_q <= 1'b0;
      reset_ok_q <= 1'b0;
      dut_rst_n_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      mm_q <= mm_d;
      first_bad_q <= first_bad_d;
      pass_q <= pass_d;
      reset_ok_q <= reset_ok_d;
      dut_rst_n_q <= dut_rst_n_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign dut_rst_n = dut_rst_n_q;
  assign busy = busy_q;
  assign done = done_q;
  assign pass = pass_q;
  assign reset_ok = reset_ok_q;
  assign mismatch_count = mm_q;
  assign first_bad = first_bad_q;
endmodule
